// File: rtl/approx_pkg.sv
// rtl/approx_pkg.sv - shared types and default widths for the approximate-skip decider
//
// Purpose: decider state encoding, default parameter widths and the
// configuration bundle layout used by the fetch-side approximation logic.
package approx_pkg;

    localparam int PROB_W_DEF   = 8;
    localparam int RAND_W_DEF   = 32;
    localparam int STREAK_W_DEF = 4;
    localparam int CNT_W_DEF    = 32;

    typedef enum logic {
        RUN      = 1'b0,
        COOLDOWN = 1'b1
    } approx_state_t;

    typedef struct packed {
        logic                    enable;
        logic [PROB_W_DEF-1:0]   threshold;
        logic [STREAK_W_DEF-1:0] max_streak;
        logic [STREAK_W_DEF-1:0] cooldown;
    } approx_cfg_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: counts inc_i pulses and sticks at all-ones instead of wrapping.
// Ports:
//   clk      clock
//   clear_i  synchronous clear (has priority over inc_i)
//   inc_i    increment request
//   count_o  current count
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/approx_skip_decider.sv
// rtl/approx_skip_decider.sv - probabilistic skip/execute decider for approximable fetches
//
// Purpose: for each accepted approximable instruction, decides skip when the
// low PROB_W bits of the random sample fall below cfg_threshold. Consecutive
// skips are bounded by cfg_max_streak, after which cfg_cooldown approximable
// requests are forced to execute. The decision is registered (1-cycle latency)
// behind a valid/ready handshake; two saturating counters track activity.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   randomval                   random sample (only low PROB_W bits used)
//   cfg_enable                  approximation enable
//   cfg_threshold               skip probability = cfg_threshold / 2^PROB_W
//   cfg_max_streak              max consecutive skips, 0 = unlimited
//   cfg_cooldown                forced-execute requests after a full streak
//   req_valid, req_approx       request in, approximable flag
//   req_ready                   decider can accept
//   resp_valid, resp_skip       registered decision out
//   resp_ready                  downstream consumes decision
//   stat_approx_cnt             accepted approximable requests (saturating)
//   stat_skip_cnt               skip decisions issued (saturating)
module approx_skip_decider
    import approx_pkg::*;
#(
    parameter int PROB_W   = PROB_W_DEF,
    parameter int RAND_W   = RAND_W_DEF,
    parameter int STREAK_W = STREAK_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RAND_W-1:0]   randomval,
    input  logic                cfg_enable,
    input  logic [PROB_W-1:0]   cfg_threshold,
    input  logic [STREAK_W-1:0] cfg_max_streak,
    input  logic [STREAK_W-1:0] cfg_cooldown,
    input  logic                req_valid,
    input  logic                req_approx,
    output logic                req_ready,
    output logic                resp_valid,
    output logic                resp_skip,
    input  logic                resp_ready,
    output logic [CNT_W-1:0]    stat_approx_cnt,
    output logic [CNT_W-1:0]    stat_skip_cnt
);

    approx_state_t       state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [STREAK_W-1:0] cool_q, cool_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_skip_q, resp_skip_d;

    logic                accept;
    logic                hit;
    logic                skip;
    logic [STREAK_W:0]   streak_inc;
    logic [STREAK_W-1:0] cool_dec;
    logic                unused_rand_hi;

    // Upper random bits are intentionally ignored; only the low PROB_W bits
    // set the probability resolution.
    assign unused_rand_hi = ^randomval[RAND_W-1:PROB_W];

    assign req_ready = !resp_valid_q || resp_ready;
    assign accept    = req_valid && req_ready;
    assign hit       = randomval[PROB_W-1:0] < cfg_threshold;
    assign skip      = cfg_enable && req_approx && (state_q == RUN) && hit;

    // One extra bit so a limit of 2^STREAK_W-1 is reachable without wrap.
    assign streak_inc = {1'b0, streak_q} + (STREAK_W+1)'(1);
    assign cool_dec   = cool_q - STREAK_W'(1);

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_skip_d  = resp_skip_q;
        state_d      = state_q;
        streak_d     = streak_q;
        cool_d       = cool_q;

        // New decision replaces a consumed one in the same cycle (no bubble).
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_skip_d  = skip;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
            resp_skip_d  = 1'b0;
        end

        if (!cfg_enable) begin
            state_d  = RUN;
            streak_d = '0;
            cool_d   = '0;
        end else if (accept && req_approx) begin
            case (state_q)
                RUN: begin
                    if (skip) begin
                        if ((cfg_max_streak != '0) &&
                            (streak_inc == {1'b0, cfg_max_streak})) begin
                            streak_d = '0;
                            if (cfg_cooldown != '0) begin
                                state_d = COOLDOWN;
                                cool_d  = cfg_cooldown;
                            end
                        end else begin
                            streak_d = streak_inc[STREAK_W-1:0];
                        end
                    end else begin
                        streak_d = '0;
                    end
                end
                COOLDOWN: begin
                    cool_d = cool_dec;
                    if (cool_dec == '0) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            streak_q     <= '0;
            cool_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_skip_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            cool_q       <= cool_d;
            resp_valid_q <= resp_valid_d;
            resp_skip_q  <= resp_skip_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_skip  = resp_skip_q;

    sat_counter #(.WIDTH(CNT_W)) u_approx_cnt (
        .clk     (clk),
        .clear_i (rst),
        .inc_i   (accept && req_approx),
        .count_o (stat_approx_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_skip_cnt (
        .clk     (clk),
        .clear_i (rst),
        .inc_i   (accept && skip),
        .count_o (stat_skip_cnt)
    );

endmodule

// File: tb/tb_approx_skip_decider.sv
// tb/tb_approx_skip_decider.sv - scoreboard bench for approx_skip_decider
module tb_approx_skip_decider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] randomval = '0;
    logic        cfg_enable = 1'b0;
    logic [7:0]  cfg_threshold = '0;
    logic [3:0]  cfg_max_streak = '0;
    logic [3:0]  cfg_cooldown = '0;
    logic        req_valid = 1'b0;
    logic        req_approx = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_skip;
    logic        resp_ready = 1'b0;
    logic [31:0] stat_approx_cnt;
    logic [31:0] stat_skip_cnt;

    approx_skip_decider dut (
        .clk             (clk),
        .rst             (rst),
        .randomval       (randomval),
        .cfg_enable      (cfg_enable),
        .cfg_threshold   (cfg_threshold),
        .cfg_max_streak  (cfg_max_streak),
        .cfg_cooldown    (cfg_cooldown),
        .req_valid       (req_valid),
        .req_approx      (req_approx),
        .req_ready       (req_ready),
        .resp_valid      (resp_valid),
        .resp_skip       (resp_skip),
        .resp_ready      (resp_ready),
        .stat_approx_cnt (stat_approx_cnt),
        .stat_skip_cnt   (stat_skip_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: counts of consecutive skips and remaining forced executes.
    bit m_valid;
    int m_streak;
    int m_cool;
    int m_approx_cnt;
    int m_skip_cnt;
    bit exp_q[$];

    bit stall_seen = 1'b0;
    bit held_skip  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_valid      = 1'b0;
        m_streak     = 0;
        m_cool       = 0;
        m_approx_cnt = 0;
        m_skip_cnt   = 0;
        exp_q.delete();
    endtask

    // Inputs are already driven; evaluate this cycle at the falling edge.
    task automatic cycle();
        bit ready, acc, active, hit, sk;
        @(negedge clk);
        check("req_ready", req_ready, !m_valid || resp_ready);
        check("resp_valid", resp_valid, m_valid);
        check("stat_approx_cnt", stat_approx_cnt, m_approx_cnt);
        check("stat_skip_cnt", stat_skip_cnt, m_skip_cnt);
        ready = !m_valid || resp_ready;
        acc   = req_valid && ready;
        if (acc) begin
            active = cfg_enable && req_approx;
            hit    = int'(randomval % 256) < int'(cfg_threshold);
            sk     = active && (m_cool == 0) && hit;
            if (active) begin
                if (m_cool > 0) begin
                    m_cool--;
                end else if (sk) begin
                    m_streak++;
                    if (cfg_max_streak != 0 && m_streak == int'(cfg_max_streak)) begin
                        m_streak = 0;
                        m_cool   = int'(cfg_cooldown);
                    end
                end else begin
                    m_streak = 0;
                end
            end
            if (req_approx) m_approx_cnt++;
            if (sk) m_skip_cnt++;
            exp_q.push_back(sk);
            m_valid = 1'b1;
        end else if (resp_ready) begin
            m_valid = 1'b0;
        end
        if (!cfg_enable) begin
            m_streak = 0;
            m_cool   = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic req(input bit approx, input logic [31:0] rv, input bit rdy);
        req_valid  = 1'b1;
        req_approx = approx;
        randomval  = rv;
        resp_ready = rdy;
        cycle();
    endtask

    // Monitor: pops expected decision whenever the DUT hands one off.
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_seen && resp_valid) check("hold_skip", resp_skip, held_skip);
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", resp_valid, 1'b0);
                end else begin
                    check("resp_skip", resp_skip, exp_q.pop_front());
                end
            end
            stall_seen = resp_valid && !resp_ready;
            held_skip  = resp_skip;
        end else begin
            stall_seen = 1'b0;
        end
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_skip", resp_skip, 1'b0);
        check("rst_approx_cnt", stat_approx_cnt, 0);
        check("rst_skip_cnt", stat_skip_cnt, 0);
        check("rst_req_ready", req_ready, 1'b1);

        // Threshold boundary
        cfg_enable = 1'b1; cfg_max_streak = 4'd0; cfg_cooldown = 4'd0;
        cfg_threshold = 8'h40;
        req(1'b1, 32'hABCD_EF40, 1'b1);
        cfg_threshold = 8'h41;
        req(1'b1, 32'h1234_5640, 1'b1);
        do_reset();
        cfg_threshold = 8'h00;
        for (int i = 0; i < 100; i++) req(1'b1, $urandom, 1'b1);
        req_valid = 1'b0;
        cycle();
        check("thr0_approx_cnt", stat_approx_cnt, 100);
        check("thr0_skip_cnt", stat_skip_cnt, 0);

        // Streak / cooldown: expect 1,1,1,0,0,1,1
        do_reset();
        cfg_max_streak = 4'd3; cfg_cooldown = 4'd2; cfg_threshold = 8'hFF;
        for (int i = 0; i < 7; i++) req(1'b1, 32'h0, 1'b1);
        req_valid = 1'b0;
        cycle();
        check("streak_skip_cnt", stat_skip_cnt, 5);

        // Widest streak limit
        do_reset();
        cfg_max_streak = 4'd15; cfg_cooldown = 4'd1;
        for (int i = 0; i < 17; i++) req(1'b1, 32'h0, 1'b1);
        req_valid = 1'b0;
        cycle();
        check("max15_skip_cnt", stat_skip_cnt, 16);

        // Backpressure
        do_reset();
        cfg_max_streak = 4'd0;
        req(1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            req(1'b1, $urandom, 1'b0);
            check("bp_req_ready", req_ready, 1'b0);
            check("bp_resp_skip", resp_skip, 1'b1);
        end
        req(1'b1, 32'h0000_0080, 1'b1);
        req_valid = 1'b0;
        cycle();

        // Non-approximable interleave, then enable drop in cooldown
        do_reset();
        cfg_max_streak = 4'd2; cfg_cooldown = 4'd3;
        req(1'b1, 32'h0, 1'b1);
        req(1'b0, 32'h0, 1'b1);
        req(1'b1, 32'h0, 1'b1);
        check("ni_approx_cnt", stat_approx_cnt, 2);
        req(1'b1, 32'h0, 1'b1);
        cfg_enable = 1'b0;
        req(1'b1, 32'h0, 1'b1);
        req(1'b1, 32'h0, 1'b1);
        cfg_enable = 1'b1;
        req(1'b1, 32'h0, 1'b1);
        req_valid = 1'b0;
        cycle();
        check("en_skip_cnt", stat_skip_cnt, 3);

        // Reset mid-cooldown with a pending response
        do_reset();
        cfg_max_streak = 4'd1; cfg_cooldown = 4'd3;
        req(1'b1, 32'h0, 1'b1);
        req(1'b1, 32'h0, 1'b0);
        check("pend_valid", resp_valid, 1'b1);
        do_reset();
        check("rr_resp_valid", resp_valid, 1'b0);
        check("rr_approx_cnt", stat_approx_cnt, 0);
        req(1'b1, 32'h0, 1'b1);
        req_valid = 1'b0;
        cycle();
        check("rr_skip_cnt", stat_skip_cnt, 1);

        // Randomized traffic
        for (int ph = 0; ph < 3; ph++) begin
            do_reset();
            cfg_max_streak = 4'($urandom_range(0, 6));
            cfg_cooldown   = 4'($urandom_range(0, 4));
            for (int i = 0; i < 300; i++) begin
                cfg_enable    = ($urandom_range(0, 9) != 0);
                cfg_threshold = 8'($urandom_range(0, 255));
                req_valid     = 1'($urandom);
                req_approx    = ($urandom_range(0, 3) != 0);
                resp_ready    = ($urandom_range(0, 3) != 0);
                randomval     = $urandom;
                cycle();
            end
            req_valid  = 1'b0;
            resp_ready = 1'b1;
            repeat (3) cycle();
            check("drain_empty", exp_q.size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/approx_skip_decider.md
Name: approx_skip_decider

Overview:
- Fetch-unit block directly downstream of the LFSR random source.
- Per fetched approximable instruction, makes a probabilistic skip/execute decision: skip when the LFSR sample falls below a programmable threshold.
- Bounds consecutive skips with a streak limiter and a cooldown state machine.
- Emits a registered decision to the fetch pipeline with valid/ready handshake, plus saturating statistics counters.

Parameters:
- PROB_W, 8, width of probability threshold; compares randomval[PROB_W-1:0].
- RAND_W, 32, width of incoming random value.
- STREAK_W, 4, width of streak limit and cooldown counters.
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- randomval  in  RAND_W  LFSR output; new value every cycle.
- cfg_enable  in  1  approximation enable.
- cfg_threshold  in  PROB_W  skip probability = cfg_threshold / 2^PROB_W.
- cfg_max_streak  in  STREAK_W  max consecutive skips; 0 = unlimited.
- cfg_cooldown  in  STREAK_W  number of approximable requests forced non-skip after the streak limit is hit.
- req_valid  in  1  fetch presents an instruction.
- req_approx  in  1  instruction is marked approximable.
- req_ready  out  1  decider can accept.
- resp_valid  out  1  decision valid.
- resp_skip  out  1  1 = skip instruction.
- resp_ready  in  1  downstream consumes decision.
- stat_approx_cnt  out  CNT_W  accepted approximable requests.
- stat_skip_cnt  out  CNT_W  skip decisions issued.

Behaviour:
- Reset: resp_valid=0, resp_skip=0, state=RUN, streak=0, cool_cnt=0, both stat counters=0. Reset mid-operation drops any pending response.
- Handshake:
  - req_ready = !resp_valid || resp_ready (combinational).
  - Accept = req_valid && req_ready.
  - Latency is 1: the decision is registered on the accept edge; resp_valid=1 the next cycle.
  - With no accept and resp_ready=1, resp_valid clears.
  - While resp_valid && !resp_ready, resp_valid and resp_skip hold stable regardless of randomval or cfg changes.
- Decision at accept: hit = randomval[PROB_W-1:0] < cfg_threshold (unsigned, strict).
  - skip = cfg_enable && req_approx && state==RUN && hit.
  - Threshold 0 never skips. Maximum threshold skips with probability 255/256 (PROB_W=8).
- States RUN and COOLDOWN. All transitions happen only on accepted requests with req_approx=1 and cfg_enable=1. Non-approximable requests change no state.
- RUN:
  - skip → streak+1. If cfg_max_streak!=0 and streak+1==cfg_max_streak:
    - streak←0.
    - If cfg_cooldown==0, stay in RUN; else go to COOLDOWN with cool_cnt←cfg_cooldown.
  - No skip → streak←0.
- COOLDOWN:
  - Decision forced 0.
  - cool_cnt decrements; when the decremented value is 0, go to RUN.
- cfg_enable=0: all decisions 0; state←RUN, streak←0, cool_cnt←0 at the next edge.
- Streak arithmetic uses STREAK_W+1 bits internally so that 2^STREAK_W-1 compares correctly.
- Counters: on each accept with req_approx=1, stat_approx_cnt+1; on each skip decision, stat_skip_cnt+1. Both saturate at all-ones and do not wrap.
- A simultaneous accept and resp_ready loads the new decision (no bubble).

Decomposition:
- Package approx_pkg:
  - approx_state_t enum {RUN, COOLDOWN}.
  - PROB_W/STREAK_W/CNT_W defaults.
  - approx_cfg_t struct (enable, threshold, max_streak, cooldown).
- Sub-module sat_counter (width parameter; inc and clear inputs; saturates at all-ones), instantiated twice for the stats.

Test Plan:
- Threshold boundary: PROB_W=8, randomval[7:0]=0x40, threshold=0x40 → resp_skip=0. Threshold=0x41 → resp_skip=1. Threshold=0 with 100 random requests → 0 skips, stat_approx_cnt=100.
- Streak/cooldown: max_streak=3, cooldown=2, threshold=0xFF, randomval=0, 7 approximable requests → skip pattern 1,1,1,0,0,1,1; stat_skip_cnt=5.
- Backpressure: accept a skip decision, then hold resp_ready=0 for 3 cycles while randomval changes → resp_valid=1 and resp_skip=1 held, req_ready=0. Release → new request accepted the same cycle.
- Non-approximable interleave: max_streak=2; sequence approx-skip, non-approx, approx-skip → enter COOLDOWN after the third request. The non-approx response has skip=0 and stat_approx_cnt=2.
- Enable drop: cfg_enable=0 while in COOLDOWN → all decisions 0. Re-enable → state RUN, streak 0, next hit skips.
- Reset mid-cooldown with a pending unconsumed response → next cycle resp_valid=0, counters 0, state RUN, next hit skips.
